pipeline_sched: RTL and testbench

//  Multi-core, multi-buffer dispatch scheduler. Generalises the single-core / single-activation-buffer start sequencer.

---
 rtl/pipeline_sched.sv | 136 +++++++++++++
 tb/tb_pipeline_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sched.sv
// Multi-core dispatch scheduler: keeps a ring of DEPTH activation slots filled
// through a single outstanding load and hands each filled slot to the lowest free core.
module pipeline_sched #(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 2,
    parameter int SLOT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 init_signal,
    input  logic                 activate_ready,
    input  logic [NUM_CORES-1:0] core_end,
    output logic [NUM_CORES-1:0] start_core,
    output logic [SLOT_W-1:0]    core_slot,
    output logic                 start_load,
    output logic [SLOT_W-1:0]    load_slot,
    output logic [SLOT_W:0]      slots_valid,
    output logic                 busy,
    output logic                 proto_err
);

    localparam logic [SLOT_W:0]   DEPTH_V   = (SLOT_W + 1)'(DEPTH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH - 1);

    logic [SLOT_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [SLOT_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                 load_busy_q, load_busy_d;
    logic [SLOT_W:0]      slots_valid_q, slots_valid_d;
    logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
    logic                 proto_err_q, proto_err_d;
    logic [NUM_CORES-1:0] start_core_q, start_core_d;
    logic [SLOT_W-1:0]    core_slot_q, core_slot_d;
    logic                 start_load_q, start_load_d;
    logic [SLOT_W-1:0]    load_slot_q, load_slot_d;
    logic                 busy_q, busy_d;

    logic [NUM_CORES-1:0] free_cores;
    logic [NUM_CORES-1:0] pick_core;
    logic                 load_go;
    logic                 load_done;
    logic                 disp_go;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + SLOT_W'(1);
    endfunction

    // A core finishing this cycle is not yet eligible; x & -x isolates the lowest free core.
    assign free_cores = ~core_busy_q & ~core_end;
    assign pick_core  = free_cores & (~free_cores + NUM_CORES'(1));

    assign load_go   = !load_busy_q
                     && ((slots_valid_q + {{SLOT_W{1'b0}}, load_busy_q}) < DEPTH_V)
                     && (en || init_signal);
    assign load_done = activate_ready && load_busy_q;
    assign disp_go   = en && (slots_valid_q != '0) && (|free_cores);

    // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        load_busy_d   = load_busy_q;
        slots_valid_d = slots_valid_q;
        core_busy_d   = core_busy_q & ~core_end;
        start_core_d  = '0;
        core_slot_d   = core_slot_q;
        start_load_d  = 1'b0;
        load_slot_d   = load_slot_q;
        proto_err_d   = proto_err_q
                      | (activate_ready & ~load_busy_q)
                      | (|(core_end & ~core_busy_q));

        if (load_go) begin
            start_load_d = 1'b1;
            load_slot_d  = wr_ptr_q;
            load_busy_d  = 1'b1;
        end
        if (load_done) begin
            wr_ptr_d    = next_slot(wr_ptr_q);
            load_busy_d = 1'b0;
        end

        if (disp_go) begin
            start_core_d = pick_core;
            core_slot_d  = rd_ptr_q;
            core_busy_d  = core_busy_d | pick_core;
            rd_ptr_d     = next_slot(rd_ptr_q);
        end

        case ({load_done, disp_go})
            2'b10:   slots_valid_d = slots_valid_q + (SLOT_W + 1)'(1);
            2'b01:   slots_valid_d = slots_valid_q - (SLOT_W + 1)'(1);
            default: slots_valid_d = slots_valid_q;
        endcase

        busy_d = (|core_busy_d) | load_busy_d | (slots_valid_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            load_busy_q   <= 1'b0;
            slots_valid_q <= '0;
            core_busy_q   <= '0;
            proto_err_q   <= 1'b0;
            start_core_q  <= '0;
            core_slot_q   <= '0;
            start_load_q  <= 1'b0;
            load_slot_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            load_busy_q   <= load_busy_d;
            slots_valid_q <= slots_valid_d;
            core_busy_q   <= core_busy_d;
            proto_err_q   <= proto_err_d;
            start_core_q  <= start_core_d;
            core_slot_q   <= core_slot_d;
            start_load_q  <= start_load_d;
            load_slot_q   <= load_slot_d;
            busy_q        <= busy_d;
        end
    end

    assign start_core  = start_core_q;
    assign core_slot   = core_slot_q;
    assign start_load  = start_load_q;
    assign load_slot   = load_slot_q;
    assign slots_valid = slots_valid_q;
    assign busy        = busy_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_pipeline_sched.sv
// Directed bench for pipeline_sched (NUM_CORES=4, DEPTH=2): load/dispatch ordering,
// saturation, coincident events, protocol errors and asynchronous reset.
module tb_pipeline_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       init_signal;
    logic       activate_ready;
    logic [3:0] core_end;
    logic [3:0] start_core;
    logic [0:0] core_slot;
    logic       start_load;
    logic [0:0] load_slot;
    logic [1:0] slots_valid;
    logic       busy;
    logic       proto_err;

    int compared   = 0;
    int mismatched = 0;

    pipeline_sched #(.NUM_CORES(4), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .init_signal    (init_signal),
        .activate_ready (activate_ready),
        .core_end       (core_end),
        .start_core     (start_core),
        .core_slot      (core_slot),
        .start_load     (start_load),
        .load_slot      (load_slot),
        .slots_valid    (slots_valid),
        .busy           (busy),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start_core"},  32'(start_core),  32'h0);
        check({tag, "_core_slot"},   32'(core_slot),   32'h0);
        check({tag, "_start_load"},  32'(start_load),  32'h0);
        check({tag, "_load_slot"},   32'(load_slot),   32'h0);
        check({tag, "_slots_valid"}, 32'(slots_valid), 32'h0);
        check({tag, "_busy"},        32'(busy),        32'h0);
        check({tag, "_proto_err"},   32'(proto_err),   32'h0);
    endtask

    // One dispatch round: dispatch + load issue, two idle cycles, loader reply.
    task automatic t2_round(input logic [3:0] exp_core, input logic exp_cslot, input logic exp_lslot);
        tick();
        check("t2_start_core", 32'(start_core), 32'(exp_core));
        check("t2_core_slot",  32'(core_slot),  32'(exp_cslot));
        check("t2_start_load", 32'(start_load), 32'h1);
        check("t2_load_slot",  32'(load_slot),  32'(exp_lslot));
        tick();
        tick();
        activate_ready = 1'b1;
        tick();
        activate_ready = 1'b0;
        check("t2_slots_valid", 32'(slots_valid), 32'h1);
    endtask

    initial begin
        rst_n          = 1'b0;
        en             = 1'b0;
        init_signal    = 1'b0;
        activate_ready = 1'b0;
        core_end       = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // T1: init-driven load with en=0
        init_signal = 1'b1;
        tick();
        init_signal = 1'b0;
        check("t1_start_load", 32'(start_load), 32'h1);
        check("t1_load_slot",  32'(load_slot),  32'h0);
        check("t1_start_core", 32'(start_core), 32'h0);
        check("t1_busy",       32'(busy),       32'h1);
        tick();
        check("t1_load_pulse_end", 32'(start_load), 32'h0);
        activate_ready = 1'b1;
        tick();
        activate_ready = 1'b0;
        check("t1_slots_valid", 32'(slots_valid), 32'h1);
        check("t1_busy_filled", 32'(busy),        32'h1);
        tick();
        check("t1_no_auto_load", 32'(start_load), 32'h0);
        check("t1_no_dispatch",  32'(start_core), 32'h0);

        // T2: dispatch order across cores, alternating slots
        en = 1'b1;
        t2_round(4'b0001, 1'b0, 1'b1);
        t2_round(4'b0010, 1'b1, 1'b0);
        t2_round(4'b0100, 1'b0, 1'b1);
        t2_round(4'b1000, 1'b1, 1'b0);
        tick();
        check("fill_start_load", 32'(start_load), 32'h1);
        check("fill_load_slot",  32'(load_slot),  32'h1);
        check("fill_no_core",    32'(start_core), 32'h0);
        tick();
        activate_ready = 1'b1;
        tick();
        activate_ready = 1'b0;
        check("fill_slots_valid", 32'(slots_valid), 32'h2);

        // T3: saturated, then one core frees
        tick();
        check("t3_no_load",     32'(start_load),  32'h0);
        check("t3_no_dispatch", 32'(start_core),  32'h0);
        check("t3_slots_full",  32'(slots_valid), 32'h2);
        core_end = 4'b0100;
        tick();
        core_end = 4'b0000;
        check("t3_not_same_cycle", 32'(start_core), 32'h0);
        tick();
        check("t3_start_core", 32'(start_core),  32'h4);
        check("t3_core_slot",  32'(core_slot),   32'h0);
        check("t3_slots_dec",  32'(slots_valid), 32'h1);
        check("t3_load_later", 32'(start_load),  32'h0);
        tick();
        check("t3_load_issue", 32'(start_load), 32'h1);
        check("t3_load_slot",  32'(load_slot),  32'h0);

        // T4: activate_ready coincides with a dispatch
        core_end = 4'b0001;
        tick();
        core_end = 4'b0000;
        check("t4_prep_no_core", 32'(start_core), 32'h0);
        activate_ready = 1'b1;
        tick();
        activate_ready = 1'b0;
        check("t4_start_core",  32'(start_core),  32'h1);
        check("t4_core_slot",   32'(core_slot),   32'h1);
        check("t4_slots_same",  32'(slots_valid), 32'h1);
        core_end = 4'b0010;
        tick();
        core_end = 4'b0000;
        check("t4_wr_advanced", 32'(load_slot),  32'h1);
        check("t4_load_issue",  32'(start_load), 32'h1);
        check("t4_core_freeing", 32'(start_core), 32'h0);
        tick();
        check("t4_rd_advanced", 32'(core_slot),   32'h0);
        check("t4_start_core1", 32'(start_core),  32'h2);
        check("t4_slots_zero",  32'(slots_valid), 32'h0);
        check("t4_no_proto",    32'(proto_err),   32'h0);

        // T5: spurious activate_ready
        activate_ready = 1'b1;
        tick();
        check("t5_legit_ready", 32'(proto_err),   32'h0);
        check("t5_slots_one",   32'(slots_valid), 32'h1);
        tick();
        activate_ready = 1'b0;
        check("t5_proto_set",   32'(proto_err),   32'h1);
        check("t5_load_issue",  32'(start_load),  32'h1);
        check("t5_load_slot",   32'(load_slot),   32'h0);
        check("t5_slots_kept",  32'(slots_valid), 32'h1);

        // T6: async reset with two cores still busy
        en       = 1'b0;
        core_end = 4'b1100;
        tick();
        core_end = 4'b0000;
        check("t6_proto_sticky", 32'(proto_err),  32'h1);
        check("t6_busy",         32'(busy),       32'h1);
        check("t6_no_core",      32'(start_core), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        init_signal = 1'b1;
        tick();
        init_signal = 1'b0;
        check("r1_start_load", 32'(start_load),  32'h1);
        check("r1_load_slot",  32'(load_slot),   32'h0);
        check("r1_start_core", 32'(start_core),  32'h0);
        check("r1_proto_clr",  32'(proto_err),   32'h0);
        check("r1_slots",      32'(slots_valid), 32'h0);
        activate_ready = 1'b1;
        tick();
        activate_ready = 1'b0;
        check("r2_slots_valid", 32'(slots_valid), 32'h1);
        check("r2_busy",        32'(busy),        32'h1);

        // Late core_end to a free core
        core_end = 4'b0001;
        tick();
        core_end = 4'b0000;
        check("r3_proto_free_core", 32'(proto_err),  32'h1);
        check("r3_no_core",         32'(start_core), 32'h0);
        tick();
        check("r4_proto_sticky", 32'(proto_err),   32'h1);
        check("r4_slots_valid",  32'(slots_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("final_proto_clr", 32'(proto_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
